// File: rtl/score_bcd_feeder_if.sv
// Handshake bundle between the score feeder and its driver.
// The display multiplexer side also reads from this bundle.
interface score_bcd_feeder_if;
  logic       score_add;
  logic [1:0] add_pts;
  logic       clr;
  logic       scan_en;
  logic [3:0] d1;
  logic [3:0] d0;
  logic [6:0] score_bin;
  logic       busy;

  modport master (output score_add, add_pts, clr,
                  input  scan_en, d1, d0, score_bin, busy);
  modport slave  (input  score_add, add_pts, clr,
                  output scan_en, d1, d0, score_bin, busy);
endinterface

// File: rtl/score_bcd_feeder.sv
// Saturating score accumulator with a sequential double-dabble BCD converter.
// Also produces the display scan tick.
module score_bcd_feeder #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int SCAN_HZ   = 4_000,
  parameter int MAX_SCORE = 99
) (
  input  logic               clk,
  input  logic               rst,
  score_bcd_feeder_if.slave  bus
);

  localparam int DIV = CLK_HZ / SCAN_HZ;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [6:0] MAX7 = 7'(MAX_SCORE);

  logic [6:0]    score;
  logic [6:0]    score_nxt;
  logic [7:0]    sum;
  logic          changed;
  logic          dirty;
  logic [1:0]    state;
  logic [14:0]   shreg;
  logic [14:0]   adj;
  logic [2:0]    iter;
  logic [3:0]    d1_q, d0_q;
  logic          busy_q;
  logic [CW-1:0] cnt;

  // Sum is 8 bits wide so 99+3 cannot wrap before the saturation compare.
  always_comb begin
    sum       = {1'b0, score} + {6'b0, bus.add_pts};
    score_nxt = score;
    if (bus.clr)
      score_nxt = '0;
    else if (bus.score_add)
      score_nxt = (sum > {1'b0, MAX7}) ? MAX7 : sum[6:0];
    changed = (score_nxt != score);
  end

  always_comb begin
    adj = shreg;
    if (shreg[14:11] >= 4'd5) adj[14:11] = shreg[14:11] + 4'd3;
    if (shreg[10:7]  >= 4'd5) adj[10:7]  = shreg[10:7]  + 4'd3;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      score  <= '0;
      dirty  <= 1'b0;
      state  <= S_IDLE;
      shreg  <= '0;
      iter   <= '0;
      d1_q   <= '0;
      d0_q   <= '0;
      busy_q <= 1'b0;
    end else begin
      score <= score_nxt;
      // A new change wins over the clear that accompanies a load.
      dirty <= changed || (dirty && state != S_IDLE);
      case (state)
        S_IDLE: if (dirty) begin
          shreg  <= {8'b0, score};
          iter   <= '0;
          state  <= S_SHIFT;
          busy_q <= 1'b1;
        end
        S_SHIFT: begin
          shreg <= adj << 1;
          iter  <= iter + 3'd1;
          if (iter == 3'd6) state <= S_DONE;
        end
        S_DONE: begin
          // Result already stale: skip the latch and reconvert, keeping busy high.
          if (!dirty) begin
            d1_q   <= shreg[14:11];
            d0_q   <= shreg[10:7];
            busy_q <= 1'b0;
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                      cnt <= '0;
    else if (cnt == CW'(DIV - 1)) cnt <= '0;
    else                          cnt <= cnt + 1'b1;
  end

  assign bus.scan_en   = (cnt == CW'(DIV - 1));
  assign bus.d1        = d1_q;
  assign bus.d0        = d0_q;
  assign bus.score_bin = score;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_score_bcd_feeder.sv
// Scoreboard bench: stimulus pushes expected digits, a monitor pops them
// whenever busy falls (a conversion result is latched).
module tb_score_bcd_feeder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  score_bcd_feeder_if bus();

  score_bcd_feeder #(.CLK_HZ(1000), .SCAN_HZ(100), .MAX_SCORE(99)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );

  typedef struct {
    logic [3:0] d1;
    logic [3:0] d0;
    logic [6:0] score;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   checks   = 0;
  int   failures = 0;
  logic prev_busy = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && prev_busy && !bus.busy) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected actual=%0d%0d expected=none", bus.d1, bus.d0);
      end else begin
        e = q.pop_front();
        chk("sb_d1", 32'(bus.d1), 32'(e.d1));
        chk("sb_d0", 32'(bus.d0), 32'(e.d0));
        chk("sb_score", 32'(bus.score_bin), 32'(e.score));
      end
    end
    prev_busy = rst ? 1'b0 : bus.busy;
  end

  task automatic sync();
    @(posedge clk); #1;
  endtask

  task automatic pulse(input logic a, input logic [1:0] p, input logic c);
    bus.score_add = a; bus.add_pts = p; bus.clr = c;
    sync();
    bus.score_add = 1'b0; bus.add_pts = 2'd0; bus.clr = 1'b0;
  endtask

  task automatic push(input logic [3:0] t, input logic [3:0] o, input logic [6:0] s);
    exp_t x;
    x.d1 = t; x.d0 = o; x.score = s;
    q.push_back(x);
  endtask

  task automatic settle();
    repeat (25) sync();
    chk("sb_drained", 32'(q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bus.score_add = 1'b0; bus.add_pts = 2'd0; bus.clr = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_score", 32'(bus.score_bin), 32'd0);
    chk("rst_d1", 32'(bus.d1), 32'd0);
    chk("rst_d0", 32'(bus.d0), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_scan", 32'(bus.scan_en), 32'd0);
    sync();

    // Three spaced +3 shots, exact 9-cycle latency on the last
    push(0, 3, 3);  pulse(1, 3, 0); repeat (11) sync();
    push(0, 6, 6);  pulse(1, 3, 0); repeat (11) sync();
    push(0, 9, 9);  pulse(1, 3, 0);
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      if (j == 9)  chk("lat_d0_hold", 32'(bus.d0), 32'd6);
      if (j == 10) chk("lat_d0_new", 32'(bus.d0), 32'd9);
    end
    sync();
    settle();

    // Clear then burst to 98, saturate at 99, further add ignored
    push(9, 8, 98);
    pulse(0, 0, 1);
    for (int i = 0; i < 32; i++) pulse(1, 3, 0);
    pulse(1, 2, 0);
    settle();
    push(9, 9, 99);
    pulse(1, 2, 0);
    settle();
    pulse(1, 3, 0);
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      chk("sat_idle_busy", 32'(bus.busy), 32'd0);
    end
    chk("sat_score", 32'(bus.score_bin), 32'd99);
    chk("sat_d1", 32'(bus.d1), 32'd9);
    sync();

    // Build 42, then clr and add together: clr wins
    push(4, 2, 42);
    pulse(0, 0, 1);
    for (int i = 0; i < 14; i++) pulse(1, 3, 0);
    settle();
    push(0, 0, 0);
    pulse(1, 3, 1);
    @(negedge clk);
    chk("clr_wins_score", 32'(bus.score_bin), 32'd0);
    sync();
    settle();

    // Score 10, add 2 then add 3 mid-conversion: no 1/2 ever shown
    push(1, 0, 10);
    pulse(1, 3, 0); pulse(1, 3, 0); pulse(1, 3, 0); pulse(1, 1, 0);
    settle();
    push(1, 5, 15);
    pulse(1, 2, 0);
    sync();
    pulse(1, 3, 0);
    for (int j = 1; j <= 16; j++) begin
      @(negedge clk);
      chk("reconv_busy", 32'(bus.busy), 32'd1);
      chk("reconv_hold", 32'({bus.d1, bus.d0}), 32'h10);
    end
    sync();
    settle();

    // Reset mid-conversion aborts; scan period restarts
    pulse(1, 3, 0);
    repeat (3) sync();
    rst = 1'b1;
    sync();
    rst = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (n == 1) begin
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_score", 32'(bus.score_bin), 32'd0);
        chk("abort_digits", 32'({bus.d1, bus.d0}), 32'h00);
      end
      chk("scan_tick", 32'(bus.scan_en), (n % 10 == 0) ? 32'd1 : 32'd0);
    end
    sync();
    settle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
